// File: rtl/arp_sequencer.sv
// Key-to-voice arbiter for a keyboard synth: round-robin arpeggiator or
// lowest-key mono priority, with a step timer pacing the arpeggio.
module arp_sequencer #(
    parameter int NKEYS      = 13,
    parameter int STEP_TICKS = 1_250_000
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic [NKEYS-1:0] keys,
    output logic [3:0]       note_idx,
    output logic             note_valid,
    output logic             strobe,
    output logic [23:0]      step_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam logic [23:0] STEP_LAST = 24'(STEP_TICKS - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  idx_nx;
    logic        valid_nx;
    logic        strobe_nx;
    logic [23:0] step_nx;

    logic        key_any;
    logic        cur_held;
    logic        timer_done;
    logic [3:0]  low_idx;
    logic [3:0]  high_idx;
    logic [3:0]  adv_idx;

    function automatic logic bit_at(input logic [NKEYS-1:0] k, input int i);
        logic [NKEYS-1:0] kb;
        kb = k >> i;
        return kb[0];
    endfunction

    function automatic logic [3:0] lowest_key(input logic [NKEYS-1:0] k);
        logic [3:0] r;
        r = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (bit_at(k, i)) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] highest_key(input logic [NKEYS-1:0] k);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (bit_at(k, i)) r = 4'(i);
        end
        return r;
    endfunction

    // Scan offsets from farthest to nearest so the nearest held key in the
    // travel direction wins; with no other key held the grant stays put.
    function automatic logic [3:0] next_key(input logic [NKEYS-1:0] k,
                                            input logic [3:0] cur,
                                            input logic down);
        logic [3:0] r;
        int         cand;
        r = cur;
        for (int off = NKEYS - 1; off >= 1; off--) begin
            if (down) cand = int'(cur) - off;
            else      cand = int'(cur) + off;
            if (cand < 0)           cand = cand + NKEYS;
            else if (cand >= NKEYS) cand = cand - NKEYS;
            if (bit_at(k, cand)) r = 4'(cand);
        end
        return r;
    endfunction

    assign key_any    = |keys;
    assign cur_held   = bit_at(keys, int'(note_idx));
    assign timer_done = (step_cnt == STEP_LAST);
    assign low_idx    = lowest_key(keys);
    assign high_idx   = highest_key(keys);
    assign adv_idx    = next_key(keys, note_idx, dir);

    always_comb begin
        state_nx  = state;
        idx_nx    = note_idx;
        valid_nx  = note_valid;
        strobe_nx = 1'b0;
        step_nx   = '0;
        case (state)
            IDLE: begin
                valid_nx = 1'b0;
                if (en && key_any) begin
                    state_nx  = PLAY;
                    idx_nx    = dir ? high_idx : low_idx;
                    valid_nx  = 1'b1;
                    strobe_nx = 1'b1;
                end
            end
            PLAY: begin
                if (!en || !key_any) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                end else begin
                    valid_nx = 1'b1;
                    if (mode) begin
                        idx_nx    = low_idx;
                        strobe_nx = (low_idx != note_idx);
                    end else if (!cur_held || timer_done) begin
                        // Release and expiry on the same cycle merge into one advance.
                        idx_nx    = adv_idx;
                        strobe_nx = (adv_idx != note_idx);
                    end else begin
                        step_nx = step_cnt + 24'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            note_idx   <= '0;
            note_valid <= 1'b0;
            strobe     <= 1'b0;
            step_cnt   <= '0;
        end else begin
            state      <= state_nx;
            note_idx   <= idx_nx;
            note_valid <= valid_nx;
            strobe     <= strobe_nx;
            step_cnt   <= step_nx;
        end
    end

endmodule

// File: tb/tb_arp_sequencer.sv
// Directed bench for arp_sequencer with a list-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_arp_sequencer;

    localparam int NKEYS      = 13;
    localparam int STEP_TICKS = 4;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             dir = 1'b0;
    logic [NKEYS-1:0] keys = '0;
    logic [3:0]       note_idx;
    logic             note_valid;
    logic             strobe;
    logic [23:0]      step_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    // Reference model state
    bit m_playing = 1'b0;
    int m_idx     = 0;
    bit m_valid   = 1'b0;
    bit m_strobe  = 1'b0;
    int m_step    = 0;

    arp_sequencer #(.NKEYS(NKEYS), .STEP_TICKS(STEP_TICKS)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .mode       (mode),
        .dir        (dir),
        .keys       (keys),
        .note_idx   (note_idx),
        .note_valid (note_valid),
        .strobe     (strobe),
        .step_cnt   (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ring_next(input int held[$], input int cur, input bit down);
        if (!down) begin
            foreach (held[j]) if (held[j] > cur) return held[j];
            return held[0];
        end
        for (int j = held.size() - 1; j >= 0; j--) if (held[j] < cur) return held[j];
        return held[held.size() - 1];
    endfunction

    task automatic model_update();
        int         held[$];
        int         nxt;
        bit         released;
        logic [31:0] kw;
        logic [31:0] sh;
        if (!nrst) begin
            m_playing = 1'b0; m_idx = 0; m_valid = 1'b0; m_strobe = 1'b0; m_step = 0;
            return;
        end
        kw = 32'(keys);
        for (int i = 0; i < NKEYS; i++) begin
            sh = kw >> i;
            if (sh[0]) held.push_back(i);
        end
        m_strobe = 1'b0;
        if (!m_playing) begin
            m_step = 0;
            if (en && held.size() > 0) begin
                m_playing = 1'b1;
                m_valid   = 1'b1;
                m_strobe  = 1'b1;
                m_idx     = dir ? held[held.size() - 1] : held[0];
            end
        end else if (!en || held.size() == 0) begin
            m_playing = 1'b0;
            m_valid   = 1'b0;
            m_step    = 0;
        end else if (mode) begin
            m_step   = 0;
            nxt      = held[0];
            m_strobe = (nxt != m_idx);
            m_idx    = nxt;
        end else begin
            released = 1'b1;
            foreach (held[j]) if (held[j] == m_idx) released = 1'b0;
            if (released || m_step == STEP_TICKS - 1) begin
                nxt      = ring_next(held, m_idx, dir);
                m_strobe = (nxt != m_idx);
                m_idx    = nxt;
                m_step   = 0;
            end else begin
                m_step++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge nrst);
        model_update();
    end

    // Scoreboard compare on the falling edge, away from register updates
    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            check("model note_idx",   int'(note_idx),   m_idx);
            check("model note_valid", int'(note_valid), int'(m_valid));
            check("model strobe",     int'(strobe),     int'(m_strobe));
            check("model step_cnt",   int'(step_cnt),   m_step);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit e, input bit m, input bit d, input logic [NKEYS-1:0] k);
        en   = e;
        mode = m;
        dir  = d;
        keys = k;
    endtask

    int strobes;

    initial begin
        tick(3);
        cmp_on = 1'b1;
        check("reset note_idx",   int'(note_idx),   0);
        check("reset note_valid", int'(note_valid), 0);
        check("reset strobe",     int'(strobe),     0);
        check("reset step_cnt",   int'(step_cnt),   0);
        nrst = 1'b1;
        tick(1);

        // Ascending arpeggio on keys 2 and 4
        drive(1, 0, 0, 13'h0014);
        tick(1);
        check("asc entry idx",    int'(note_idx),   2);
        check("asc entry strobe", int'(strobe),     1);
        check("asc entry valid",  int'(note_valid), 1);
        tick(3);
        check("asc step3",        int'(step_cnt),   3);
        tick(1);
        check("asc adv idx",      int'(note_idx),   4);
        check("asc adv strobe",   int'(strobe),     1);
        tick(4);
        check("asc wrap idx",     int'(note_idx),   2);
        drive(0, 0, 0, 13'h0014);
        tick(1);
        check("disable valid",    int'(note_valid), 0);
        check("disable holds idx", int'(note_idx),  2);

        // Descending arpeggio
        drive(1, 0, 1, 13'h0014);
        tick(1);
        check("desc entry idx",   int'(note_idx),   4);
        tick(4);
        check("desc adv idx",     int'(note_idx),   2);
        tick(4);
        check("desc wrap idx",    int'(note_idx),   4);
        check("desc wrap strobe", int'(strobe),     1);
        drive(0, 0, 1, 13'h0014);
        tick(1);

        // Release of the granted key forces an early advance
        drive(1, 0, 0, 13'h0114);
        tick(5);
        check("rel on note 4",    int'(note_idx),   4);
        tick(1);
        check("rel step 1",       int'(step_cnt),   1);
        drive(1, 0, 0, 13'h0104);
        tick(1);
        check("rel adv idx",      int'(note_idx),   8);
        check("rel adv strobe",   int'(strobe),     1);
        check("rel step reset",   int'(step_cnt),   0);

        // Direction change only affects the next advance
        drive(1, 0, 1, 13'h0104);
        tick(1);
        check("dir no jump idx",  int'(note_idx),   8);
        tick(3);
        check("dir next adv",     int'(note_idx),   2);

        // Mono mode priority tracking
        drive(1, 1, 0, 13'h0104);
        tick(1);
        drive(1, 1, 0, 13'h1000);
        tick(1);
        check("mono idx 12",      int'(note_idx),   12);
        drive(1, 1, 0, 13'h1008);
        tick(1);
        check("mono idx 3",       int'(note_idx),   3);
        check("mono strobe",      int'(strobe),     1);
        check("mono step",        int'(step_cnt),   0);
        drive(1, 1, 0, 13'h1000);
        tick(1);
        check("mono back 12",     int'(note_idx),   12);

        // Back to arpeggio: timer restarts, top key wraps to key 0
        drive(1, 0, 0, 13'h1001);
        tick(1);
        check("m2a no strobe",    int'(strobe),     0);
        check("m2a step",         int'(step_cnt),   1);
        tick(3);
        check("top wrap idx",     int'(note_idx),   0);

        // Expiry and release on the same cycle
        drive(0, 0, 0, 13'h0014);
        tick(1);
        drive(1, 0, 0, 13'h0014);
        tick(4);
        check("coinc step3",      int'(step_cnt),   3);
        drive(1, 0, 0, 13'h0010);
        tick(1);
        check("coinc idx",        int'(note_idx),   4);
        tick(1);
        check("coinc one strobe", int'(strobe),     0);

        // Single held key strobes once
        drive(0, 0, 0, 13'h0000);
        tick(1);
        drive(1, 0, 0, 13'h0001);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (strobe) strobes++;
        end
        check("single key strobes", strobes, 1);
        drive(1, 0, 0, 13'h0000);
        tick(1);
        check("keys off valid",   int'(note_valid), 0);

        // Asynchronous reset mid-step
        drive(1, 0, 0, 13'h0014);
        tick(2);
        #2;
        nrst = 1'b0;
        #1;
        check("async rst idx",    int'(note_idx),   0);
        check("async rst valid",  int'(note_valid), 0);
        check("async rst step",   int'(step_cnt),   0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        tick(1);
        check("post rst idx",     int'(note_idx),   2);
        check("post rst strobe",  int'(strobe),     1);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arp_sequencer.md
ARP_SEQUENCER -- requirements
Module: arp_sequencer

Interface
REQ-001 SHALL have parameter NKEYS, default 13, number of note keys (one-hot requesters).
REQ-002 SHALL have parameter STEP_TICKS, default 1_250_000, clocks per arpeggio step; legal range 2..2^24-1.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  sequencer enable; low forces IDLE.
REQ-006 SHALL have port mode  input  1  0 = arpeggio (round-robin), 1 = mono (lowest-index priority).
REQ-007 SHALL have port dir  input  1  arpeggio direction; 0 = ascending index, 1 = descending.
REQ-008 SHALL have port keys  input  NKEYS  held-key vector, already synchronized/debounced, bit i = key i held.
REQ-009 SHALL have port note_idx  output  4  index of the key currently granted the sound datapath.
REQ-010 SHALL have port note_valid  output  1  high while note_idx is granted.
REQ-011 SHALL have port strobe  output  1  one-cycle pulse whenever a new grant is issued.
REQ-012 SHALL have port step_cnt  output  24  current step-timer value, for debug.

Function
REQ-013 SHALL implement FSM states IDLE and PLAY; all outputs registered.
REQ-014 IDLE: note_valid=0, step_cnt=0, note_idx holds last value; strobe=0.
REQ-015 IDLE->PLAY when en=1 and keys!=0: next cycle note_idx=lowest set bit (dir=0) or highest set bit (dir=1), note_valid=1, strobe=1, step_cnt=0; latency exactly one clock.
REQ-016 PLAY->IDLE when en=0 or keys==0: next cycle note_valid=0, step_cnt=0, strobe=0; takes precedence over every other PLAY event.
REQ-017 PLAY, mode=0: step_cnt increments each clock; at step_cnt==STEP_TICKS-1 it wraps to 0 and the grant advances.
REQ-018 Advance rule: next set bit strictly above note_idx (dir=0) or strictly below (dir=1), wrapping around the vector end; if no other bit set, grant stays on note_idx.
REQ-019 strobe SHALL pulse on an advance only if note_idx changes; a single held key produces one strobe at entry only.
REQ-020 PLAY, mode=0: if keys[note_idx] drops while other keys held, grant SHALL advance per REQ-018 on the next cycle, step_cnt reset to 0, strobe=1, regardless of timer.
REQ-021 PLAY, mode=1: step_cnt held at 0; note_idx SHALL track the lowest set bit of keys each cycle, strobe=1 on the cycle note_idx changes.
REQ-022 Mode change mid-PLAY SHALL take effect the next cycle; 1->0 restarts step_cnt at 0 without strobe; 0->1 re-evaluates lowest key per REQ-021.
REQ-023 dir change mid-PLAY SHALL affect only the next advance; no immediate grant change.
REQ-024 Timer expiry and current-key release on the same cycle SHALL produce exactly one advance and one strobe.
REQ-025 Bits of keys above NKEYS-1 do not exist; note_idx SHALL never exceed NKEYS-1.
REQ-026 strobe SHALL never be high for two consecutive cycles unless note_idx changes on both.

Reset
REQ-027 nrst low SHALL asynchronously force state=IDLE, note_idx=0, note_valid=0, strobe=0, step_cnt=0.
REQ-028 Reset mid-PLAY SHALL abandon the grant with no strobe; first grant after release follows REQ-015 with at least one clock latency.

Verification (STEP_TICKS=4)
REQ-029 keys=0x0014, mode=0, dir=0, en=1 from IDLE -> cycle+1 note_idx=2, strobe=1; after 4 clocks note_idx=4, strobe=1; after 4 more note_idx=2 (wrap).
REQ-030 Same keys, dir=1 -> entry note_idx=4; then 2, 4, 2 every 4 clocks with strobe each change.
REQ-031 PLAY on note 4 of keys=0x0114, drop bit 4 at step_cnt=1 -> next cycle note_idx=8, strobe=1, step_cnt=0.
REQ-032 mode=1, keys 0x1000 then 0x1008 then 0x1000 -> note_idx 12, 3, 12, strobe on each change, step_cnt stays 0.
REQ-033 Single key 0x0001 held 20 clocks -> exactly one strobe; then keys=0 -> next cycle note_valid=0.
REQ-034 nrst pulsed low mid-step in PLAY -> outputs zero immediately without waiting for clk; after release with keys held, grant reissued with strobe one cycle later.
